// File: rtl/f3m_pkg.sv
// f3m_pkg: shared GF(3^M) trit encodings, default field size and accumulator state codes
package f3m_pkg;
    localparam int F3M_M = 97;
    localparam int F3M_W = 2 * F3M_M;
    localparam logic [1:0] TRIT_0 = 2'b00;
    localparam logic [1:0] TRIT_1 = 2'b01;
    localparam logic [1:0] TRIT_2 = 2'b10;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC = 2'd1;
    localparam logic [1:0] OUT = 2'd2;
endpackage

// File: rtl/f3m_addsub.sv
// f3m_addsub: per-trit a + (neg ? -b : b) mod 3 with illegal-trit sanitising of b
module f3m_addsub
    import f3m_pkg::*;
#(
    parameter int M = F3M_M
) (
    input  logic [2*M-1:0] a,
    input  logic [2*M-1:0] b,
    input  logic           neg,
    output logic [2*M-1:0] sum,
    output logic           illegal
);
    logic [M-1:0] ill;
    for (genvar i = 0; i < M; i++) begin : g_trit
        logic [1:0] t;
        logic [1:0] n;
        logic [2:0] s;
        assign ill[i] = &b[2*i+:2];
        assign t = ill[i] ? TRIT_0 : b[2*i+:2];
        // negation in this encoding is a bit swap: 1 <-> 2, 0 stays 0
        assign n = neg ? {t[0], t[1]} : t;
        assign s = {1'b0, a[2*i+:2]} + {1'b0, n};
        // s is 0..4; subtracting 3 from 3 or 4 is the same as adding 1 mod 4
        assign sum[2*i+:2] = (s >= 3'd3) ? s[1:0] + 2'd1 : s[1:0];
    end
    assign illegal = |ill;
endmodule

// File: rtl/f3m_acc_seq.sv
// f3m_acc_seq: streaming multi-operand GF(3^M) add/subtract accumulator with valid/ready ports
module f3m_acc_seq
    import f3m_pkg::*;
#(
    parameter int M     = F3M_M,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*M-1:0]   in_data,
    input  logic             in_neg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*M-1:0]   out_data,
    output logic             out_err,
    output logic             busy
);
    logic [1:0]       state;
    logic [2*M-1:0]   acc;
    logic [CNT_W-1:0] rem;
    logic             err;
    logic [2*M-1:0]   sum;
    logic             ill;

    f3m_addsub #(.M(M)) u_addsub (
        .a(acc),
        .b(in_data),
        .neg(in_neg),
        .sum(sum),
        .illegal(ill)
    );

    assign in_ready  = state == ACC;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign out_data  = acc;
    assign out_err   = err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= '0;
                    err   <= 1'b0;
                    rem   <= count;
                    state <= (count != '0) ? ACC : OUT;
                end
                ACC: if (in_valid) begin
                    acc <= sum;
                    err <= err | ill;
                    rem <= rem - 1'b1;
                    if (rem == 1) state <= OUT;
                end
                OUT: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/f3m_acc_seq.md
Name: f3m_acc_seq

Overview:
- Sequential, parametrised multi-operand GF(3^M) adder/subtractor.
- Accepts a programmed number of operands, one per cycle, over a valid/ready stream, each tagged add or subtract. Returns the single sum over a valid/ready output.
- Sits between operand producers (mult/cube units) and consumers in the pairing datapath.
- Replaces fixed three-input combinational addition with an arbitrary operand count and signed accumulation.

Parameters:
- M, 97, number of trits per GF(3^M) element; data width 2*M bits.
- CNT_W, 8, width of the operand-count field; up to 2^CNT_W-1 operands per job.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  job request; sampled only in IDLE.
- count  in  CNT_W  operand count for the job; latched with start.
- in_valid  in  1  operand valid.
- in_ready  out  1  operand accepted when in_valid & in_ready.
- in_data  in  2*M  operand; trit i at bits [2i+1:2i].
- in_neg  in  1  1 = subtract operand, 0 = add; qualified by in_valid.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  2*M  accumulated result.
- out_err  out  1  at least one illegal trit (2'b11) seen in this job; valid with out_valid.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Trit encoding: 00 = 0, 01 = 1, 10 = 2, 11 illegal. Each illegal input trit is treated as 0 and sets the sticky error flag.
- Negation of a trit swaps its two bits (1 <-> 2; 0 stays 0).
- Per-trit sum is mod 3.
- Internal regs: acc[2M-1:0], rem[CNT_W-1:0], err, 2-bit state.
- Reset (asynchronous assert, synchronous deassert by the system): state = IDLE, acc = 0, rem = 0, err = 0. Outputs in_ready = 0, out_valid = 0, out_data = 0, out_err = 0, busy = 0.
- IDLE:
  - in_ready = 0, out_valid = 0.
  - start & count != 0 -> ACC; acc <= 0, err <= 0, rem <= count.
  - start & count == 0 -> OUT; acc <= 0, err <= 0.
- ACC:
  - in_ready = 1.
  - On handshake: acc <= acc + (in_neg ? -in_data : in_data); err <= err | any illegal trit; rem <= rem - 1.
  - Handshake with rem == 1 -> OUT.
  - No handshake: state and acc hold.
  - One operand per cycle sustained.
- OUT:
  - out_valid = 1, out_data = acc, out_err = err, in_ready = 0.
  - out_ready -> IDLE. acc is retained (out_data keeps its last value) until the next start.
  - out_valid stays high and out_data stays stable until accepted.
- Latency: out_valid rises the cycle after the last operand handshake. Count 0 gives out_valid the cycle after start.
- start outside IDLE is ignored. A new start is accepted in the cycle after the OUT handshake, never in the same cycle.
- Reset asserted mid-job aborts the job immediately. All state returns to reset values and no partial result is presented.
- in_data/in_neg are ignored whenever in_ready = 0.
- The acc register is never written with 2'b11 trits; out_data always holds legal encodings.

Decomposition:
- Shared package f3m_pkg:
  - trit constants TRIT_0 = 2'b00, TRIT_1 = 2'b01, TRIT_2 = 2'b10.
  - state encoding IDLE/ACC/OUT.
  - the M default and the 2*M width macro, shared with the other field blocks.
- Sub-module f3m_addsub:
  - combinational; inputs A, B (2*M), neg, illegal-trit flag output.
  - sanitises B (11 -> 00), conditionally negates it, and adds per trit mod 3.
  - purely combinational; FSM and registers stay in f3m_acc_seq.

Test Plan:
- M=97, count=3, add operands 1, 1, 1 (trit 0 = 01, others 0) -> out_data trit 0 = 00 (1+1+1 = 0 mod 3), all other trits 0, out_err = 0, out_valid one cycle after third handshake.
- count=2, operand A = all trits 2, operand B = all trits 1 with in_neg = 1 -> every trit 01 (2-1); then count=1, in_neg = 1, operand all 1 -> every trit 10.
- count=0 start -> out_valid next cycle, out_data = 0, out_err = 0; any in_valid pulses are not accepted (in_ready = 0).
- count=4 with in_valid toggling every other cycle and out_ready held low for 5 cycles -> correct sum; out_data stable and out_valid high throughout the stall; start pulses during busy are ignored.
- count=2, operand trit 5 = 2'b11, other trit 5 = 01 -> result trit 5 = 01, out_err = 1; next job with legal data -> out_err = 0.
- Assert reset after 2 of 5 operands -> all outputs 0 and busy = 0 at once; a fresh job count=1, operand = trit 0 = 10 -> out_data trit 0 = 10, with no residue from the aborted job.
